// File: rtl/ofmap_writer.sv
// Drains a snapshot of the systolic array result bus into the ofmap SRAM one row per word,
// optionally accumulating onto the partial sums already stored (read-modify-write).
module ofmap_writer #(
   parameter int WIDTH           = 16,
   parameter int SRAM_ADDR_WIDTH = 10,
   parameter int I               = 4,
   parameter int J               = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       acc,
   input  logic [SRAM_ADDR_WIDTH-1:0] base_addr,
   input  logic [I*J*WIDTH-1:0]       result,
   output logic                       sram_we,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [J*WIDTH-1:0]         sram_din,
   input  logic [J*WIDTH-1:0]         sram_dout,
   output logic                       busy,
   output logic                       done,
   output logic [2:0]                 dbg_state
);

   localparam int ROW_W    = (I > 1) ? $clog2(I) : 1;
   localparam int ROW_BITS = J * WIDTH;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_ADDW  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                     state_q, state_d;
   logic [ROW_W-1:0]           row_q, row_d;
   logic [I*J*WIDTH-1:0]       snap_q, snap_d;
   logic [SRAM_ADDR_WIDTH-1:0] base_q, base_d;
   logic                       acc_q, acc_d;

   logic                       last_row;
   logic [SRAM_ADDR_WIDTH-1:0] row_addr;
   logic [ROW_BITS-1:0]        snap_row;
   logic [ROW_BITS-1:0]        sum_row;

   assign last_row = (row_q == ROW_W'(I - 1));
   // Address arithmetic wraps naturally at the top of the SRAM.
   assign row_addr = base_q + SRAM_ADDR_WIDTH'(row_q);
   assign snap_row = snap_q[row_q*ROW_BITS +: ROW_BITS];

   // Lane-wise sum: each element wraps on its own, no carry into its neighbour.
   always_comb begin
      sum_row = '0;
      for (int j = 0; j < J; j++) begin
         sum_row[j*WIDTH +: WIDTH] = snap_row[j*WIDTH +: WIDTH] + sram_dout[j*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      snap_d  = snap_q;
      base_d  = base_q;
      acc_d   = acc_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               snap_d  = result;
               base_d  = base_addr;
               acc_d   = acc;
               row_d   = '0;
               state_d = acc ? S_READ : S_WRITE;
            end
         end
         S_WRITE: begin
            if (last_row) state_d = S_DONE;
            else          row_d   = row_q + ROW_W'(1);
         end
         S_READ: begin
            state_d = S_ADDW;
         end
         S_ADDW: begin
            if (last_row) begin
               state_d = S_DONE;
            end else begin
               row_d   = row_q + ROW_W'(1);
               state_d = S_READ;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         snap_q  <= '0;
         base_q  <= '0;
         acc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         snap_q  <= snap_d;
         base_q  <= base_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      sram_we   = (state_q == S_WRITE) || (state_q == S_ADDW);
      busy      = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_ADDW);
      done      = (state_q == S_DONE);
      sram_addr = busy ? row_addr : '0;
      sram_din  = '0;
      if (state_q == S_WRITE) sram_din = snap_row;
      if (state_q == S_ADDW)  sram_din = sum_row;
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_ofmap_writer.sv
// Bench for ofmap_writer: SRAM model, per-cycle reference of the drain schedule, stimulus table,
// randomized drains and hand-written corner sequences (reset mid-drain, held start).
module tb_ofmap_writer;

   localparam int W  = 16;
   localparam int AW = 10;
   localparam int NI = 4;
   localparam int NJ = 4;
   localparam int RW = NJ * W;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              acc;
   logic [AW-1:0]     base_addr;
   logic [NI*RW-1:0]  result;
   logic              sram_we;
   logic [AW-1:0]     sram_addr;
   logic [RW-1:0]     sram_din;
   logic [RW-1:0]     sram_dout;
   logic              busy;
   logic              done;
   logic [2:0]        dbg_state;

   int n_vec = 0;
   int n_err = 0;

   // SRAM model contents and the bench's own expectation of them
   logic [RW-1:0] mem     [1024];
   logic [RW-1:0] ref_mem [1024];
   logic          pl_en;
   logic [AW-1:0] pl_addr;
   logic [RW-1:0] pl_data;

   ofmap_writer #(.WIDTH(W), .SRAM_ADDR_WIDTH(AW), .I(NI), .J(NJ)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .acc(acc), .base_addr(base_addr),
      .result(result), .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din),
      .sram_dout(sram_dout), .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // synchronous-read SRAM, read data one cycle after address
   always @(posedge clk) begin
      if (pl_en)        mem[pl_addr] <= pl_data;
      else if (sram_we) mem[sram_addr] <= sram_din;
      sram_dout <= mem[sram_addr];
   end

   task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] add_elems(input logic [RW-1:0] x, input logic [RW-1:0] y);
      logic [RW-1:0] o;
      for (int j = 0; j < NJ; j++) o[j*W +: W] = x[j*W +: W] + y[j*W +: W];
      return o;
   endfunction

   task automatic preload(input logic [AW-1:0] a, input logic [RW-1:0] d);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      ref_mem[a] = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Runs one drain from a negedge in IDLE; checks every cycle against the drain schedule.
   // mode 1 disturbs result in cycle 1 and pulses start with another base in cycle 2.
   task automatic do_drain(input logic [AW-1:0] b, input logic a, input logic [NI*RW-1:0] res,
                           input int mode, output int done_cyc, output logic [AW-1:0] last_addr);
      logic [RW-1:0] exp_w [NI];
      logic [AW-1:0] ad;
      logic          ewe, ebusy, edone, rd_cyc;
      logic [AW-1:0] eaddr;
      logic [RW-1:0] edin;
      int            ncyc;
      for (int r = 0; r < NI; r++) begin
         ad = b + AW'(r);
         exp_w[r] = a ? add_elems(res[r*RW +: RW], ref_mem[ad]) : res[r*RW +: RW];
         ref_mem[ad] = exp_w[r];
      end
      start = 1'b1; acc = a; base_addr = b; result = res;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      ncyc = a ? 2*NI + 1 : NI + 1;
      done_cyc = -1;
      last_addr = '0;
      for (int c = 1; c <= ncyc; c++) begin
         if (c > 1) @(negedge clk);
         ewe = 1'b0; eaddr = '0; edin = '0; ebusy = 1'b1; edone = 1'b0; rd_cyc = 1'b0;
         if (c == ncyc) begin
            ebusy = 1'b0; edone = 1'b1;
         end else if (!a) begin
            ewe = 1'b1; eaddr = b + AW'(c - 1); edin = exp_w[c-1];
         end else if (c % 2 == 1) begin
            rd_cyc = 1'b1; eaddr = b + AW'((c - 1) / 2);
         end else begin
            ewe = 1'b1; eaddr = b + AW'(c / 2 - 1); edin = exp_w[c/2-1];
         end
         chk("we", RW'(sram_we), RW'(ewe));
         chk("busy", RW'(busy), RW'(ebusy));
         chk("done", RW'(done), RW'(edone));
         chk("addr", RW'(sram_addr), RW'(eaddr));
         if (!rd_cyc) chk("din", sram_din, edin);
         if (done) done_cyc = c;
         if (sram_we) last_addr = sram_addr;
         if (mode == 1) begin
            if (c == 1) result = ~res;
            if (c == 2) begin start = 1'b1; base_addr = b ^ 10'h155; end
            if (c == 3) start = 1'b0;
         end
      end
      @(negedge clk);
      chk("idle_busy", RW'(busy), '0);
      chk("idle_we", RW'(sram_we), '0);
   endtask

   typedef struct {
      logic [AW-1:0] base;
      logic          acc;
      logic [W-1:0]  pre;
      logic [W-1:0]  snap;
      logic [W-1:0]  exp_elem;
      int            exp_done;
      logic [AW-1:0] exp_last;
   } vec_t;

   vec_t             tbl [5];
   logic [NI*RW-1:0] pe_res;
   logic [NI*RW-1:0] rres;
   logic [RW-1:0]    wexp;
   int               dc;
   logic [AW-1:0]    la;
   logic [AW-1:0]    rb;
   logic             ra;

   initial begin
      tbl[0] = '{10'h010, 1'b0, 16'h5555, 16'h0042, 16'h0042, 5, 10'h013};
      tbl[1] = '{10'h020, 1'b1, 16'h0100, 16'h0023, 16'h0123, 9, 10'h023};
      tbl[2] = '{10'h3FE, 1'b0, 16'h0000, 16'h0007, 16'h0007, 5, 10'h001};
      tbl[3] = '{10'h040, 1'b1, 16'hFFFF, 16'h0002, 16'h0001, 9, 10'h043};
      tbl[4] = '{10'h3FF, 1'b1, 16'h1000, 16'h0234, 16'h1234, 9, 10'h002};

      rst_n = 1'b0; start = 1'b0; acc = 1'b0; base_addr = '0; result = '0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      @(negedge clk);
      for (int k = 0; k < 1024; k++) preload(AW'(k), {$urandom(), $urandom()});

      // reset state
      chk("rst_we", RW'(sram_we), '0);
      chk("rst_addr", RW'(sram_addr), '0);
      chk("rst_din", sram_din, '0);
      chk("rst_busy", RW'(busy), '0);
      chk("rst_done", RW'(done), '0);
      chk("rst_state", RW'(dbg_state), '0);
      rst_n = 1'b1;
      @(negedge clk);

      // plain drain, PE(i,j) = i*16+j
      for (int i = 0; i < NI; i++)
         for (int j = 0; j < NJ; j++) pe_res[(i*NJ+j)*W +: W] = W'(i*16 + j);
      do_drain(10'h010, 1'b0, pe_res, 0, dc, la);
      chk("plain_done_cycle", RW'(dc), RW'(5));
      for (int r = 0; r < NI; r++) begin
         wexp = {W'(r*16+3), W'(r*16+2), W'(r*16+1), W'(r*16)};
         chk("plain_word", mem[10'h010 + AW'(r)], wexp);
      end

      // table of drains
      for (int t = 0; t < 5; t++) begin
         for (int r = 0; r < NI; r++) preload(tbl[t].base + AW'(r), {NJ{tbl[t].pre}});
         do_drain(tbl[t].base, tbl[t].acc, {(NI*NJ){tbl[t].snap}}, 0, dc, la);
         chk("tbl_done_cycle", RW'(dc), RW'(tbl[t].exp_done));
         chk("tbl_last_addr", RW'(la), RW'(tbl[t].exp_last));
         for (int r = 0; r < NI; r++)
            chk("tbl_word", mem[tbl[t].base + AW'(r)], {NJ{tbl[t].exp_elem}});
      end

      // start while busy, result changed after the snapshot
      do_drain(10'h080, 1'b0, pe_res, 1, dc, la);
      for (int r = 0; r < NI; r++) chk("busy_start_word", mem[10'h080 + AW'(r)], pe_res[r*RW +: RW]);
      chk("busy_start_other", mem[10'h080 ^ 10'h155], ref_mem[10'h080 ^ 10'h155]);

      // reset asserted asynchronously in cycle 2 of a plain drain
      for (int r = 0; r < NI; r++) preload(10'h100 + AW'(r), {NJ{16'hAAAA}});
      rres = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      start = 1'b1; acc = 1'b0; base_addr = 10'h100; result = rres;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we", RW'(sram_we), '0);
      chk("mid_rst_addr", RW'(sram_addr), '0);
      chk("mid_rst_din", sram_din, '0);
      chk("mid_rst_busy", RW'(busy), '0);
      chk("mid_rst_done", RW'(done), '0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("mid_rst_hold_done", RW'(done), '0);
         chk("mid_rst_hold_we", RW'(sram_we), '0);
      end
      rst_n = 1'b1;
      ref_mem[10'h100] = rres[RW-1:0];
      @(negedge clk);
      chk("mid_rst_row0", mem[10'h100], ref_mem[10'h100]);
      chk("mid_rst_row2", mem[10'h102], ref_mem[10'h102]);
      chk("mid_rst_row3", mem[10'h103], ref_mem[10'h103]);
      do_drain(10'h100, 1'b1, rres, 0, dc, la);
      chk("post_rst_done_cycle", RW'(dc), RW'(9));
      for (int r = 0; r < NI; r++) chk("post_rst_word", mem[10'h100 + AW'(r)], ref_mem[10'h100 + AW'(r)]);

      // start held high: retriggers once per IDLE visit
      start = 1'b1; acc = 1'b0; base_addr = 10'h200; result = pe_res;
      @(posedge clk);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         chk("hold_we", RW'(sram_we), RW'((c >= 1 && c <= 4) || (c >= 7 && c <= 10)));
         chk("hold_busy", RW'(busy), RW'((c >= 1 && c <= 4) || (c >= 7 && c <= 10)));
         chk("hold_done", RW'(done), RW'(c == 5 || c == 11));
         if (c == 7) begin
            chk("hold_restart_addr", RW'(sram_addr), RW'(10'h200));
            start = 1'b0;
         end
      end
      for (int r = 0; r < NI; r++) ref_mem[10'h200 + AW'(r)] = pe_res[r*RW +: RW];
      @(negedge clk);

      // randomized drains against the reference
      for (int n = 0; n < 24; n++) begin
         rb = AW'($urandom_range(0, 1023));
         ra = 1'($urandom_range(0, 1));
         rres = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         do_drain(rb, ra, rres, ($urandom_range(0, 3) == 0) ? 1 : 0, dc, la);
         chk("rnd_done_cycle", RW'(dc), RW'(ra ? 2*NI + 1 : NI + 1));
         for (int r = 0; r < NI; r++) chk("rnd_word", mem[rb + AW'(r)], ref_mem[rb + AW'(r)]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ofmap_writer.md
# ofmap_writer

Output-drain stage directly downstream of the systolic array in the GEMM datapath. On a start pulse it snapshots the array's full I×J `result` bus and writes it row by row into the ofmap SRAM, one row of J elements per SRAM word. In accumulate mode it performs read-modify-write, adding the snapshot to the partial sums already stored, so results of successive K-tiles can be summed in place.

## Interface
Parameters:
- `WIDTH`, 16: bits per element.
- `SRAM_ADDR_WIDTH`, 10: ofmap SRAM address width.
- `I`, 4: array rows, which is the number of SRAM words written per drain.
- `J`, 4: array columns, which is the number of elements per SRAM word.

Ports:
- `clk`  in  1: the only clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: drain request, sampled only in IDLE.
- `acc`  in  1: accumulate mode, latched with `start`.
- `base_addr`  in  SRAM_ADDR_WIDTH: address of row 0, latched with `start`.
- `result`  in  I*J*WIDTH: array outputs; PE(i,j) occupies `[(i*J+j)*WIDTH +: WIDTH]`.
- `sram_we`  out  1: ofmap SRAM write enable.
- `sram_addr`  out  SRAM_ADDR_WIDTH: ofmap SRAM address.
- `sram_din`  out  J*WIDTH: write data; element j occupies `[j*WIDTH +: WIDTH]`.
- `sram_dout`  in  J*WIDTH: SRAM read data, valid one cycle after the address is presented.
- `busy`  out  1: a drain is in progress.
- `done`  out  1: one-cycle pulse after the last write.

## Operation
- States: IDLE, WRITE, READ, ADDW, DONE. There is a row counter `row` of width clog2(I), or 1 bit minimum.
- **IDLE, start=1:** on this edge the block
  - latches `result` into the snapshot bank (I rows × J×WIDTH),
  - latches `base_addr` and `acc`,
  - sets `row`=0,
  - goes to WRITE if acc=0, or READ if acc=1.
- **IDLE, start=0:** stay in IDLE.
- **`start` while not in IDLE:** ignored. The snapshot and latched inputs stay frozen until the next IDLE start.
- **WRITE:**
  - Outputs: `sram_we`=1, `sram_addr`=base+row, `sram_din`=snapshot row `row`.
  - If row=I-1, go to DONE. Otherwise increment `row` and stay in WRITE.
- **READ:** `sram_we`=0, `sram_addr`=base+row. Go to ADDW.
- **ADDW:**
  - Outputs: `sram_we`=1, `sram_addr`=base+row, `sram_din`[j] = snapshot[row][j] + `sram_dout`[j].
  - If row=I-1, go to DONE. Otherwise increment `row` and go to READ.
- **DONE:** `done`=1, `sram_we`=0. Go to IDLE.
- **Arithmetic:** per-element WIDTH-bit addition, modulo 2^WIDTH, no saturation and no carry between elements.
- **Address:** base+row is computed modulo 2^SRAM_ADDR_WIDTH, so an address past the top wraps to 0.
- **Output values:**
  - `busy` = 1 in WRITE, READ and ADDW, and 0 in IDLE and DONE.
  - `sram_addr` and `sram_din` are 0 in IDLE and DONE.
  - All outputs decode combinationally from registered state only. `sram_din` in ADDW is the exception: it also depends on `sram_dout`.

## Timing
- **Reset values:** state=IDLE, row=0, snapshot=0, latched base/acc=0. `sram_we`=0, `sram_addr`=0, `sram_din`=0, `busy`=0, `done`=0.
- **Reset mid-drain:** immediate return to IDLE. No further writes are issued, and rows already written stay written.
- **Cycle numbering:** cycle 0 is the cycle in which `start` is sampled.
- **acc=0:**
  - Writes occur in cycles 1..I, row r in cycle r+1.
  - `done` is high in cycle I+1.
  - A new `start` is accepted in cycle I+2, giving I+2 cycles from start to start.
- **acc=1:**
  - Row r is read in cycle 2r+1 and written in cycle 2r+2.
  - `done` is high in cycle 2I+1.
  - A new `start` is accepted in cycle 2I+2.
- **Result bus timing:** `result` may change freely from cycle 1 on, because only the snapshot is used.
- **Back-to-back start:** `start` held high continuously re-triggers once per IDLE visit.

## Test plan
- **Plain drain:** reset; set I=J=4, WIDTH=16, PE(i,j)=16'h(i*16+j), base=0x010, acc=0, start for 1 cycle.
  - Required: `sram_we` in cycles 1–4; addr 0x010..0x013; word r = {r3,r2,r1,r0 elements}.
  - Required: `done` in cycle 5 only; `busy` high in cycles 1–4 only.
- **Accumulate:** SRAM model preloaded with every element = 16'h0100; snapshot elements = 16'h0023; acc=1.
  - Required: alternating read and write at each address; written elements = 16'h0123.
  - Required: `done` in cycle 9.
- **Wrap-around:**
  - Addresses: base=0x3FE, acc=0; required addresses 0x3FE, 0x3FF, 0x000, 0x001.
  - Element overflow: acc=1 with stored 16'hFFFF + snapshot 16'h0002; required written value 16'h0001, with no effect on neighbouring elements.
- **Start while busy:**
  - Pulse `start` in cycle 2 with a different base and `result`; required: ignored, original drain completes unchanged.
  - Change `result` in cycle 1; required: written data is the cycle-0 snapshot.
- **Reset mid-operation:** assert `rst_n`=0 asynchronously in cycle 2 of an acc=0 drain.
  - Required: all outputs go to 0 immediately; no writes to rows 2–3; `done` never pulses.
  - Required: a fresh start after reset release completes normally.
